// File: rtl/addsub16_sequencer.sv
// 16-bit add/sub sequenced over one shared 8-bit add/sub adder (low byte, then high byte).
// Ports: in_* request handshake, add_* shared adder, out_* result handshake.
// Optional: define ADDSUB_SAT_EN to clamp out_sum on signed overflow.
module addsub16_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_sub,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic [7:0]  add_s,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_carry,
  output logic        out_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic [7:0]  sum_lo_q, sum_lo_d;
  logic        c_lo_q, c_lo_d;
  logic [15:0] sum_q, sum_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;
  logic        ovf_hi;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    sum_lo_d = sum_lo_q;
    c_lo_d   = c_lo_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    in_ready = 1'b0;
    add_a    = 8'h00;
    add_b    = 8'h00;
    add_cin  = 1'b0;
    // Operand signs agree (add) or differ (sub), and result sign flips.
    ovf_hi   = ((a_q[15] ^ b_q[15]) == sub_q) &&
               (add_s[7] != a_q[15]);
    case (state_q)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          state_d = S_LO;
        end
      end
      S_LO: begin
        add_a    = a_q[7:0];
        add_b    = b_q[7:0];
        add_cin  = sub_q;
        sum_lo_d = add_s;
        c_lo_d   = add_cout ^ sub_q;
        state_d  = S_HI;
      end
      S_HI: begin
        // The adder inverts add_b when cin=1; pre-invert so the
        // net operand is b_hi (add) or ~b_hi (sub) whatever c_lo is.
        add_a   = a_q[15:8];
        add_b   = b_q[15:8] ^ {8{c_lo_q ^ sub_q}};
        add_cin = c_lo_q;
        carry_d = add_cout ^ c_lo_q;
        ovf_d   = ovf_hi;
`ifdef ADDSUB_SAT_EN
        if (ovf_hi)
          sum_d = a_q[15] ? 16'h8000 : 16'h7FFF;
        else
          sum_d = {add_s, sum_lo_q};
`else
        sum_d   = {add_s, sum_lo_q};
`endif
        state_d = S_DONE;
      end
      default: begin
        if (out_ready)
          state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      sub_q    <= 1'b0;
      sum_lo_q <= 8'h00;
      c_lo_q   <= 1'b0;
      sum_q    <= 16'h0000;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      sum_lo_q <= sum_lo_d;
      c_lo_q   <= c_lo_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub16_sequencer.sv
// Bench for addsub16_sequencer: models the shared 8-bit adder and
// checks each 16-bit result against plain integer arithmetic.
module tb_addsub16_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_s;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addsub16_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  // Shared adder: s = a + (b ^ {8{cin}}) + cin, cout = cin ^ raw carry.
  logic [8:0] adder_t;
  assign adder_t  = {1'b0, add_a} + {1'b0, add_b ^ {8{add_cin}}} + {8'd0, add_cin};
  assign add_s    = adder_t[7:0];
  assign add_cout = adder_t[8] ^ add_cin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input int hold);
    int ua, ub, u, sa, sb, r;
    logic [15:0] es;
    logic ec, eo, clo;
    logic [7:0] hi_b;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    u  = sub ? ua - ub : ua + ub;
    r  = sub ? sa - sb : sa + sb;
    es = u[15:0];
    ec = sub ? (ua >= ub) : (u >= 65536);
    eo = (r > 32767) || (r < -32768);
`ifdef ADDSUB_SAT_EN
    if (eo) es = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    clo  = sub ? (a[7:0] >= b[7:0])
               : ((int'(a[7:0]) + int'(b[7:0])) >= 256);
    hi_b = b[15:8] ^ {8{clo ^ sub}};

    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble operands and keep in_valid high: must be ignored.
    in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
    @(negedge clk);
    chk("lo_bus", {15'd0, add_a, add_b, add_cin}, {15'd0, a[7:0], b[7:0], sub});
    chk("lo_hs", {30'd0, in_ready, out_valid}, 32'd0);
    @(negedge clk);
    chk("hi_bus", {15'd0, add_a, add_b, add_cin}, {15'd0, a[15:8], hi_b, clo});
    chk("hi_hs", {30'd0, in_ready, out_valid}, 32'd0);
    @(negedge clk);
    chk("done_hs", {30'd0, in_ready, out_valid}, 32'd1);
    chk("result", {14'd0, out_sum, out_carry, out_ovf}, {14'd0, es, ec, eo});
    chk("done_bus", {15'd0, add_a, add_b, add_cin}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_hs", {30'd0, in_ready, out_valid}, 32'd1);
      chk("stall_res", {14'd0, out_sum, out_carry, out_ovf}, {14'd0, es, ec, eo});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
    in_sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out", {14'd0, out_valid, out_sum, out_carry, out_ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", {31'd0, in_ready}, 32'd1);

    run_op(16'h1234, 16'h0FCD, 1'b0, 0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0);
    run_op(16'h0100, 16'h0001, 1'b1, 0);
    run_op(16'h0000, 16'h0001, 1'b1, 1);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 2);
    run_op(16'hABCD, 16'h1357, 1'b1, 5);

    // Abort while the high byte is in flight.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'h4444; in_b = 16'h1111; in_sub = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_out", {14'd0, out_valid, out_sum, out_carry, out_ovf}, 32'd0);
    chk("abort_bus", {14'd0, in_ready, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_idle", {30'd0, in_ready, out_valid}, 32'd2);
    end
    run_op(16'h0002, 16'h0003, 1'b0, 0);

    for (int k = 0; k < 24; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
